regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
//
// PURPOSE
//   Shares the single write port (rd/wenb/wdata) of the RV32I register file
//   between two writeback sources.
//   - Port A: in-order ALU pipeline. Has priority; no buffering.
//   - Port B: long-latency unit (load/mul-div). Buffered in a FIFO; a
//     starvation counter guarantees it is eventually granted.
//   The output is registered and drives regfile rd/wenb/wdata directly.
//
// PARAMETERS
//   XLEN        32  data width of wdata and of both request ports
//   B_DEPTH     2   port-B FIFO entries (power of 2, >=2)
//   MAX_WAIT    4   consecutive cycles B head may lose to A before forced grant (>=1)
//
// PORTS
//   clk       in   1     clock; all state updates on posedge
//   reset     in   1     asynchronous, active-high reset
//   a_valid   in   1     port-A write request
//   a_rd      in   5     port-A destination register
//   a_data    in   XLEN  port-A write data
//   a_ready   out  1     port-A accepted this cycle (combinational)
//   b_valid   in   1     port-B write request
//   b_rd      in   5     port-B destination register
//   b_data    in   XLEN  port-B write data
//   b_ready   out  1     port-B FIFO can accept (= !full)
//   b_count   out  clog2(B_DEPTH)+1  current FIFO occupancy
//   wenb      out  1     regfile write enable (registered)
//   rd        out  5     regfile destination (registered)
//   wdata     out  XLEN  regfile write data (registered)
//
// BEHAVIOUR
//   Reset (async, any time): wenb=0, rd=0, wdata=0, FIFO emptied (contents
//     discarded), wait_cnt=0, b_count=0, b_ready=1. Takes effect mid-transfer.
//   Port-B FIFO:
//     - Enqueue on b_valid & b_ready.
//     - b_ready = !full. No bypass; a dequeue in the same cycle does not
//       raise b_ready.
//     - Simultaneous enqueue and dequeue leaves b_count unchanged.
//     - Pointers wrap modulo B_DEPTH.
//   Grant, evaluated each cycle:
//     - force_b = (b_count!=0) & (wait_cnt==MAX_WAIT).
//     - a_ready = !force_b.
//     - grant_a = a_valid & a_ready.
//     - grant_b = (b_count!=0) & !grant_a.
//     - Exactly one source is granted when any request is pending.
//   wait_cnt:
//     - 0 when FIFO empty or on grant_b.
//     - +1 when grant_a while b_count!=0.
//     - Saturates at MAX_WAIT.
//   Output register at posedge after the grant:
//     - wenb  <= (grant_a|grant_b) & (granted rd != 0)
//     - rd    <= granted rd
//     - wdata <= granted data
//     - No grant: wenb <= 0; rd and wdata hold.
//   Writes to x0 complete the handshake / dequeue but never raise wenb.
//   Latency:
//     - A accepted in cycle N -> wenb high in cycle N+1.
//     - B enqueued in cycle N -> earliest wenb in cycle N+2.
//   Ordering:
//     - B entries retire in FIFO order.
//     - No ordering between A and B. Upstream must not issue same-rd
//       writes on both ports concurrently.
//   At most one regfile write per cycle; wenb never high on two
//     consecutive grants of the same request.
//
// TESTING
//   1 Reset mid-op:
//     - Fill FIFO (2 entries), assert reset for 1 cycle -> b_count=0,
//       wenb=0, b_ready=1.
//     - No stale B write after release.
//   2 A only:
//     - a_valid=1, a_rd=5, a_data=0xDEADBEEF at N -> a_ready=1.
//     - N+1: wenb=1, rd=5, wdata=0xDEADBEEF.
//   3 B only:
//     - b_rd=7, b_data=0x12345678 enqueued at N -> N+2: wenb=1, rd=7,
//       wdata=0x12345678.
//     - b_count returns to 0.
//   4 Starvation:
//     - One B entry pending, a_valid held 1 -> A granted 4 cycles.
//     - 5th cycle: a_ready=0, B granted; next cycle A resumes.
//   5 Full FIFO:
//     - Enqueue 2 with a_valid held -> b_ready=0.
//     - 3rd b_valid held until b_ready=1; all 3 written in order.
//   6 x0 filter:
//     - a_rd=0, a_data=0xFFFFFFFF -> a_ready=1, wenb stays 0.
//     - Regfile x0 still reads 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between an in-order ALU port (A, priority)
// and a buffered long-latency port (B) with a starvation guard on the B FIFO head.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned B_DEPTH  = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [4:0]               a_rd,
  input  logic [XLEN-1:0]          a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [4:0]               b_rd,
  input  logic [XLEN-1:0]          b_data,
  output logic                     b_ready,
  output logic [$clog2(B_DEPTH):0] b_count,
  output logic                     wenb,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          wdata
);

  localparam int unsigned PW = $clog2(B_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [4:0]      r_rd_mem   [B_DEPTH];
  logic [XLEN-1:0] r_data_mem [B_DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count, w_count_d;
  logic [WW-1:0]   r_wait, w_wait_d;

  logic            w_nonempty, w_full, w_force_b;
  logic            w_grant_a, w_grant_b, w_enq;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CW'(B_DEPTH));
  assign w_force_b  = w_nonempty && (r_wait == WW'(MAX_WAIT));

  assign a_ready   = ~w_force_b;
  assign w_grant_a = a_valid & a_ready;
  assign w_grant_b = w_nonempty & ~w_grant_a;

  // b_ready depends only on registered occupancy, so a same-cycle dequeue never frees a slot.
  assign b_ready = ~w_full;
  assign w_enq   = b_valid & b_ready;
  assign b_count = r_count;

  assign w_sel_rd   = w_grant_a ? a_rd   : r_rd_mem[r_rptr];
  assign w_sel_data = w_grant_a ? a_data : r_data_mem[r_rptr];

  always_comb begin
    w_count_d = r_count;
    if (w_enq && !w_grant_b) begin
      w_count_d = r_count + CW'(1);
    end else if (!w_enq && w_grant_b) begin
      w_count_d = r_count - CW'(1);
    end
  end

  always_comb begin
    w_wait_d = r_wait;
    if (!w_nonempty || w_grant_b) begin
      w_wait_d = '0;
    end else if (w_grant_a && (r_wait != WW'(MAX_WAIT))) begin
      w_wait_d = r_wait + WW'(1);
    end
  end

  // Storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd_mem[r_wptr]   <= b_rd;
      r_data_mem[r_wptr] <= b_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wait  <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_grant_b) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_d;
      r_wait  <= w_wait_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wenb  <= 1'b0;
      rd    <= '0;
      wdata <= '0;
    end else if (w_grant_a || w_grant_b) begin
      wenb  <= (w_sel_rd != 5'd0);
      rd    <= w_sel_rd;
      wdata <= w_sel_data;
    end else begin
      wenb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter: a queue-based reference model predicts
// handshakes and regfile writes; a separate monitor pops expected writes and compares.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned MAXW  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            a_valid, b_valid;
  logic [4:0]      a_rd, b_rd;
  logic [XLEN-1:0] a_data, b_data;
  logic            a_ready, b_ready;
  logic [1:0]      b_count;
  logic            wenb;
  logic [4:0]      rd;
  logic [XLEN-1:0] wdata;

  regfile_wb_arbiter #(
    .XLEN    (XLEN),
    .B_DEPTH (DEPTH),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .a_valid(a_valid),
    .a_rd   (a_rd),
    .a_data (a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_rd   (b_rd),
    .b_data (b_data),
    .b_ready(b_ready),
    .b_count(b_count),
    .wenb   (wenb),
    .rd     (rd),
    .wdata  (wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              due;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  wr_t  exp_q[$];
  ent_t bq[$];
  int   losses = 0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_write(input logic [4:0] r, input logic [XLEN-1:0] d);
    wr_t w;
    if (r != 5'd0) begin
      w.due  = cyc + 1;
      w.rd   = r;
      w.data = d;
      exp_q.push_back(w);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: B waits in a queue, A wins unless B's head has already lost MAXW times.
  always @(negedge clk) begin
    if (reset) begin
      bq.delete();
      exp_q.delete();
      losses = 0;
      check("reset_b_count", 64'(b_count), 64'd0);
      check("reset_b_ready", 64'(b_ready), 64'd1);
      check("reset_wenb", 64'(wenb), 64'd0);
    end else begin
      bit   force_b, ga, gb, can_enq;
      ent_t e;
      force_b = (bq.size() > 0) && (losses == MAXW);
      ga      = a_valid && !force_b;
      gb      = !ga && (bq.size() > 0);
      can_enq = (bq.size() < DEPTH);
      check("a_ready", 64'(a_ready), 64'(!force_b));
      check("b_ready", 64'(b_ready), 64'(can_enq));
      check("b_count", 64'(b_count), 64'(bq.size()));
      if (ga) begin
        expect_write(a_rd, a_data);
        losses = (bq.size() == 0) ? 0 : ((losses < MAXW) ? losses + 1 : MAXW);
      end else if (gb) begin
        e = bq.pop_front();
        expect_write(e.rd, e.data);
        losses = 0;
      end else begin
        losses = 0;
      end
      if (b_valid && can_enq) begin
        e.rd   = b_rd;
        e.data = b_data;
        bq.push_back(e);
      end
    end
  end

  // Monitor: every cycle either the expected write is due or the port must be idle.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        wr_t w;
        w = exp_q.pop_front();
        check("wenb", 64'(wenb), 64'd1);
        check("rd", 64'(rd), 64'(w.rd));
        check("wdata", 64'(wdata), 64'(w.data));
      end else begin
        check("idle_wenb", 64'(wenb), 64'd0);
      end
      if (wenb) check("x0_write", 64'(rd == 5'd0), 64'd0);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    idle();
    a_rd   = '0;
    a_data = '0;
    b_rd   = '0;
    b_data = '0;
    repeat (2) step();
    reset = 1'b0;
    step();

    // Reset in the middle of buffered B traffic; no stale write may follow
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1111_0000;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h3333_3333;
    step();
    b_rd = 5'd4; b_data = 32'h4444_4444;
    step();
    b_valid = 1'b0;
    step();
    idle();
    reset = 1'b1;
    step();
    check("mid_reset_b_count", 64'(b_count), 64'd0);
    reset = 1'b0;
    repeat (5) step();

    // A only
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
    step();
    idle();
    repeat (2) step();

    // B only
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h1234_5678;
    step();
    idle();
    repeat (4) step();
    check("b_drained", 64'(b_count), 64'd0);

    // Starvation: A held while one B entry waits
    a_valid = 1'b1; a_rd = 5'd2; a_data = 32'hA000_0000;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'hB000_0009;
    step();
    b_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_data = 32'hA000_0001 + i;
      step();
    end
    idle();
    step();

    // Full FIFO with A held; third B waits for space
    a_valid = 1'b1; a_rd = 5'd6; a_data = 32'hAAAA_0006;
    b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hB000_000A;
    step();
    b_rd = 5'd11; b_data = 32'hB000_000B;
    step();
    b_rd = 5'd12; b_data = 32'hB000_000C;
    n = 0;
    while (!b_ready && n < 20) begin
      step();
      n++;
    end
    check("full_wait_bound", 64'(n < 20), 64'd1);
    step();
    b_valid = 1'b0;
    repeat (16) step();
    idle();
    repeat (3) step();

    // x0 writes are accepted but filtered
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
    step();
    idle();
    repeat (2) step();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        a_valid = ($urandom_range(0, 99) < 55);
        a_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        a_data  = $urandom;
        b_valid = ($urandom_range(0, 99) < 40);
        b_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        b_data  = $urandom;
        step();
      end
    end
    idle();
    repeat (20) step();
    check("drain_expected", 64'(exp_q.size()), 64'd0);
    check("drain_b_count", 64'(b_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
